// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared definitions for the memory responder slice.
//   MEM_DATA_BITS : beat width shared with the cache memory interface.
//   req_op_e      : request direction carried in the request FIFO.
//   ceilLog2      : elaboration-time helper for sizing pointers.
package mem_responder_pkg;

  localparam int unsigned MEM_DATA_BITS = 128;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_op_e;

  function automatic int unsigned ceilLog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_responder_fifo.sv
// mem_responder_fifo: synchronous first-word-fall-through FIFO.
// Ports:
//   clk, reset       : clock, synchronous active-high reset (empties FIFO)
//   push, push_data  : write request and entry (ignored when full)
//   pop              : remove head entry (ignored when empty)
//   pop_data         : current head entry, valid when !empty
//   full, empty      : occupancy flags
// DEPTH must be a power of two >= 2. Pointers carry one extra wrap bit.
module mem_responder_fifo
  import mem_responder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = ceilLog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointers equal in the low bits but differing in the wrap bit means full.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side stand-in for the DRAM controller.
// Requests {addr, rw} and write-data beats {data, mask} are queued in two
// FIFOs and paired in order. Reads return data after LATENCY cycles, in
// issue order, as a one-cycle mem_resp_valid pulse; writes are silent.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   mem_req_valid/ready/addr/rw       : request beat handshake
//   mem_req_data_valid/ready/bits/mask: write-data beat handshake
//   mem_resp_valid, mem_resp_data     : read response (data held between pulses)
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 28,
  parameter int unsigned DATA_BITS  = MEM_DATA_BITS,
  parameter int unsigned STORE_LOG2 = 12,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned QUEUE_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic                   mem_req_rw,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                   mem_resp_valid,
  output logic [DATA_BITS-1:0]   mem_resp_data
);

  localparam int unsigned MASK_BITS   = DATA_BITS / 8;
  localparam int unsigned QDEPTH      = 32'd1 << QUEUE_LOG2;
  localparam int unsigned STORE_DEPTH = 32'd1 << STORE_LOG2;
  localparam int unsigned REQ_W       = ADDR_BITS + 1;
  localparam int unsigned DAT_W       = DATA_BITS + MASK_BITS;

  logic                   req_full, req_empty, req_pop;
  logic                   dat_full, dat_empty, dat_pop;
  logic [REQ_W-1:0]       req_head;
  logic [DAT_W-1:0]       dat_head;
  logic [ADDR_BITS-1:0]   head_addr;
  req_op_e                head_op;
  logic [STORE_LOG2-1:0]  head_idx;
  logic [DATA_BITS-1:0]   wr_data;
  logic [MASK_BITS-1:0]   wr_mask;
  logic                   issue_rd, issue_wr;

  logic [DATA_BITS-1:0]   store_q [STORE_DEPTH];
  logic [LATENCY-1:0]     vld_q;
  logic [DATA_BITS-1:0]   dat_q [LATENCY];

  // Readys are held low while reset is asserted so nothing is accepted into
  // FIFOs that are being cleared; they rise on the first cycle out of reset.
  assign mem_req_ready      = !reset && !req_full;
  assign mem_req_data_ready = !reset && !dat_full;

  mem_responder_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (QDEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (mem_req_valid && mem_req_ready),
    .push_data ({mem_req_addr, mem_req_rw}),
    .pop       (req_pop),
    .pop_data  (req_head),
    .full      (req_full),
    .empty     (req_empty)
  );

  mem_responder_fifo #(
    .WIDTH (DAT_W),
    .DEPTH (QDEPTH)
  ) u_dat_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (mem_req_data_valid && mem_req_data_ready),
    .push_data ({mem_req_data_bits, mem_req_data_mask}),
    .pop       (dat_pop),
    .pop_data  (dat_head),
    .full      (dat_full),
    .empty     (dat_empty)
  );

  assign head_addr = req_head[REQ_W-1:1];
  assign head_op   = req_op_e'(req_head[0]);
  assign head_idx  = head_addr[STORE_LOG2-1:0];
  assign wr_data   = dat_head[DAT_W-1:MASK_BITS];
  assign wr_mask   = dat_head[MASK_BITS-1:0];

  // A write at the head waits for its data beat and blocks everything behind it.
  always_comb begin
    issue_rd = 1'b0;
    issue_wr = 1'b0;
    if (!reset && !req_empty) begin
      if (head_op == REQ_READ) issue_rd = 1'b1;
      else if (!dat_empty)     issue_wr = 1'b1;
    end
    req_pop = issue_rd || issue_wr;
    dat_pop = issue_wr;
  end

  // Backing store is never cleared by reset.
  always_ff @(posedge clk) begin
    if (issue_wr) begin
      for (int unsigned b = 0; b < MASK_BITS; b++) begin
        if (wr_mask[b]) store_q[head_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Stage 0 is the registered store read; later stages only advance data
  // alongside a valid, so the final stage holds the last response.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) dat_q[k] <= '0;
    end else begin
      vld_q[0] <= issue_rd;
      if (issue_rd) dat_q[0] <= store_q[head_idx];
      for (int unsigned k = 1; k < LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
      end
    end
  end

  assign mem_resp_valid = vld_q[LATENCY-1];
  assign mem_resp_data  = dat_q[LATENCY-1];

endmodule
